imem_serial_loader: RTL and testbench

// - Write-side counterpart of the core's instruction fetch: loads program words into the

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_serial_loader_sync_edge.sv | 41 ++++
 rtl/imem_serial_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_serial_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory serial loader.
// The state enum and word/byte geometry are used by the top and its bench.
package imem_loader_pkg;

    localparam int unsigned IMEM_ADDR_W = 5;
    localparam int unsigned IMEM_DEPTH  = 32;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned BYTE_CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        FULL
    } state_t;

endpackage

// File: rtl/imem_serial_loader_sync_edge.sv
// Synchronizer chain for one asynchronous level plus registered rise/fall pulses.
// Pulses line up with the cycle the last synchronizer stage changes value.
module sync_edge
    import imem_loader_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Edges are detected one stage early so the pulse lands with the new synchronized level.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
        rise_d  =  chain_q[SYNC_STAGES-2] & ~chain_q[SYNC_STAGES-1];
        fall_d  = ~chain_q[SYNC_STAGES-2] &  chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/imem_serial_loader.sv
// Loads little-endian byte streams into sequential instruction-memory words and
// holds the core in reset while a load is in progress.
module imem_serial_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = IMEM_ADDR_W,
    parameter int unsigned DEPTH       = IMEM_DEPTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              err_partial,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]       DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [BYTE_CNT_W-1:0] LAST_LANE = BYTE_CNT_W'(WORD_BYTES-1);

    logic en_rise, en_fall, valid_rise;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ld_en),
        .rise     (en_rise),
        .fall     (en_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_valid (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ld_valid),
        .rise     (valid_rise),
        .fall     ()
    );

    state_t                  state_q, state_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]             asm_q, asm_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         wc_q, wc_d;
    logic                    we_q, we_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    perr_q, perr_d;
    logic                    oerr_q, oerr_d;
    logic                    pend_q, pend_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wc_d       = wc_q;
        we_d       = 1'b0;
        hold_d     = hold_q;
        done_d     = done_q;
        perr_d     = perr_q;
        oerr_d     = oerr_q;
        pend_d     = pend_q;

        unique case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d    = LOAD;
                    hold_d     = 1'b1;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    addr_d     = '0;
                    wc_d       = '0;
                    done_d     = 1'b0;
                    perr_d     = 1'b0;
                    oerr_d     = 1'b0;
                    pend_d     = 1'b0;
                end
            end
            LOAD: begin
                // A fall deferred from COMMIT is handled here; a fall also beats a same-cycle byte.
                if (en_fall || pend_q) begin
                    state_d    = IDLE;
                    hold_d     = 1'b0;
                    pend_d     = 1'b0;
                    byte_cnt_d = '0;
                    if (byte_cnt_q == '0) done_d = 1'b1;
                    else                  perr_d = 1'b1;
                end else if (valid_rise) begin
                    asm_d[8*byte_cnt_q +: 8] = ld_byte;
                    if (byte_cnt_q == LAST_LANE) begin
                        state_d = COMMIT;
                        we_d    = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                byte_cnt_d = '0;
                wc_d       = wc_q + 1'b1;
                pend_d     = pend_q | en_fall;
                if (wc_q + 1'b1 == DEPTH_W) begin
                    state_d = FULL;
                end else begin
                    state_d = LOAD;
                    addr_d  = addr_q + 1'b1;
                end
            end
            FULL: begin
                if (en_fall || pend_q) begin
                    state_d = IDLE;
                    hold_d  = 1'b0;
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (valid_rise) begin
                    oerr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            addr_q     <= '0;
            wc_q       <= '0;
            we_q       <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            oerr_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            wc_q       <= wc_d;
            we_q       <= we_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            oerr_q     <= oerr_d;
            pend_q     <= pend_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = asm_q;
    assign core_hold    = hold_q;
    assign load_done    = done_q;
    assign err_partial  = perr_q;
    assign err_overflow = oerr_q;
    assign word_count   = wc_q;

endmodule

// File: tb/tb_imem_serial_loader.sv
// Directed bench for imem_serial_loader: a byte-stream model predicts every memory
// write and the end-of-load flags; a monitor checks each write as it happens.
module tb_imem_serial_loader;

    localparam int unsigned AW  = 5;
    localparam int unsigned DEP = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_en = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          err_partial;
    logic          err_overflow;
    logic [AW:0]   word_count;

    imem_serial_loader #(.ADDR_W(AW), .DEPTH(DEP), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_en        (ld_en),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .err_partial  (err_partial),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: the byte stream the DUT should accept determines writes and flags.
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] log_d[$];
    int unsigned exp_wc;
    bit          exp_done, exp_perr, exp_oerr;
    bit          mon_en = 1'b0;
    int unsigned phase = 0;

    function automatic void model_load(input logic [7:0] bq[$]);
        int unsigned n, nw;
        wr_t w;
        n  = bq.size();
        nw = n / 4;
        if (nw > DEP) nw = DEP;
        for (int unsigned i = 0; i < nw; i++) begin
            w.a = AW'(i);
            w.d = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
            exp_q.push_back(w);
        end
        exp_wc   = nw;
        exp_oerr = (n > 4*DEP);
        exp_perr = !exp_oerr && (n % 4 != 0);
        exp_done = !exp_perr;
    endfunction

    always @(negedge clk) begin
        wr_t w;
        if (mon_en && rst_n && imem_we) begin
            log_d.push_back(imem_wdata);
            chk("hold_during_we", 32'(core_hold), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(w.a));
                chk("wr_data", imem_wdata, w.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        ld_byte = b;
        repeat (4) @(posedge clk);
        #(1 + (phase % 8));
        phase++;
        ld_valid = 1'b1;
        #10;
        ld_valid = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic send_all(input logic [7:0] bq[$]);
        foreach (bq[i]) send_byte(bq[i]);
    endtask

    task automatic start_load();
        log_d.delete();
        @(posedge clk);
        #2;
        ld_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("hold_on", 32'(core_hold), 32'd1);
        chk("flags_cleared", 32'({load_done, err_partial, err_overflow}), 32'd0);
        chk("wc_cleared", 32'(word_count), 32'd0);
    endtask

    task automatic verify_end(input string tag);
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_hold_off"}, 32'(core_hold), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
        chk({tag, "_perr"}, 32'(err_partial), 32'(exp_perr));
        chk({tag, "_oerr"}, 32'(err_overflow), 32'(exp_oerr));
        chk({tag, "_wc"}, 32'(word_count), exp_wc);
        chk({tag, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic end_load(input string tag);
        @(posedge clk);
        #2;
        ld_en = 1'b0;
        verify_end(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(core_hold), 32'd0);
        chk({tag, "_flags"}, 32'({load_done, err_partial, err_overflow}), 32'd0);
        chk({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] bq[$];

        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);

        // Basic two-word load
        bq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        model_load(bq);
        start_load();
        send_all(bq);
        end_load("basic");
        chk("basic_nwrites", 32'(log_d.size()), 32'd2);
        chk("basic_w0", log_d[0], 32'h0000_0513);
        chk("basic_w1", log_d[1], 32'h0010_0093);
        chk("basic_done_lit", 32'(load_done), 32'd1);

        // Partial word: six bytes
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model_load(bq);
        start_load();
        send_all(bq);
        end_load("partial");
        chk("partial_nwrites", 32'(log_d.size()), 32'd1);
        chk("partial_w0", log_d[0], 32'h4433_2211);
        chk("partial_perr_lit", 32'(err_partial), 32'd1);

        // Overflow: 128 bytes fill memory, one more byte is rejected
        bq.delete();
        for (int unsigned i = 0; i < 129; i++) bq.push_back(8'(i * 7 + 3));
        model_load(bq);
        start_load();
        send_all(bq);
        end_load("overflow");
        chk("overflow_nwrites", 32'(log_d.size()), 32'd32);
        chk("overflow_addr_hold", 32'(imem_addr), 32'd31);
        chk("overflow_oerr_lit", 32'(err_overflow), 32'd1);

        // Race: ld_en fall and the 4th strobe arrive together
        bq = '{8'hA1, 8'hB2, 8'hC3};
        model_load(bq);
        start_load();
        send_all(bq);
        ld_byte = 8'hD4;
        repeat (4) @(posedge clk);
        #3;
        ld_valid = 1'b1;
        ld_en = 1'b0;
        #10;
        ld_valid = 1'b0;
        verify_end("race");
        chk("race_nwrites", 32'(log_d.size()), 32'd0);

        // Reset in the middle of a load
        bq = '{8'h01, 8'h02};
        start_load();
        send_all(bq);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        ld_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model_load(bq);
        start_load();
        send_all(bq);
        end_load("postreset");
        chk("postreset_nwrites", 32'(log_d.size()), 32'd1);
        chk("postreset_w0", log_d[0], 32'hDEAD_BEEF);

        // Narrow strobes at varied phases, closely spaced
        bq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        model_load(bq);
        start_load();
        ld_byte = 8'hA5;
        for (int unsigned i = 0; i < 8; i++) begin
            @(posedge clk);
            #(1 + (i * 3) % 8);
            ld_valid = 1'b1;
            #10;
            ld_valid = 1'b0;
            repeat (2) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        end_load("glitch");
        chk("glitch_nwrites", 32'(log_d.size()), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
